// File: rtl/br_param.sv
// Parametrised register bank: NREGS x XLEN entries, NRD registered read ports, one write port,
// zero-clearing sweep after reset. Optional write-to-read forwarding under `BR_PARAM_BYPASS_EN.
module br_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                regWrite,
    input  logic [AW-1:0]       a3,
    input  logic [XLEN-1:0]     wd3,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic                ready
);

    typedef enum logic {INIT, RUN} state_t;

    // One extra bit so the range check works when NREGS is a power of two.
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic [XLEN-1:0] mem [NREGS];

    logic            wr_ok;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;

    assign wr_ok = (state_q == RUN) && regWrite && ({1'b0, a3} < NREGS_W)
                   && !((ZERO_REG != 0) && (a3 == '0));

    // The sweep owns the write port during INIT; user writes are ignored there.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = a3;
        mem_wd = wd3;
        if (rst_n) begin
            if (state_q == INIT) begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
            end else if (wr_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign ready = ready_q;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        logic [AW-1:0]   ra_k;
        logic [XLEN-1:0] lane_d;
        logic [XLEN-1:0] lane_q;

        assign ra_k = ra[gi*AW +: AW];

        always_comb begin
            lane_d = '0;
            if ((state_q == RUN) && ({1'b0, ra_k} < NREGS_W)
                && !((ZERO_REG != 0) && (ra_k == '0))) begin
                lane_d = mem[ra_k];
`ifdef BR_PARAM_BYPASS_EN
                if (wr_ok && (ra_k == a3)) begin
                    lane_d = wd3;
                end
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign rd[gi*XLEN +: XLEN] = lane_q;
    end

endmodule

// File: tb/tb_br_param.sv
// Scoreboard bench for br_param: a 32x2 bank with zero register and a 24x3 bank without it.
module tb_br_param;

`ifdef BR_PARAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, we_a, ready_a;
    logic [4:0]  a3_a;
    logic [31:0] wd_a;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;

    logic        rst_b, we_b, ready_b;
    logic [4:0]  a3_b;
    logic [31:0] wd_b;
    logic [14:0] ra_b;
    logic [95:0] rd_b;

    br_param #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .regWrite(we_a), .a3(a3_a), .wd3(wd_a),
        .ra(ra_a), .rd(rd_a), .ready(ready_a)
    );

    br_param #(.XLEN(32), .NREGS(24), .NRD(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .regWrite(we_b), .a3(a3_b), .wd3(wd_b),
        .ra(ra_b), .rd(rd_b), .ready(ready_b)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] pick(int sel);
        case (sel)
            0:       return rd_a[31:0];
            1:       return rd_a[63:32];
            2:       return rd_b[31:0];
            3:       return rd_b[63:32];
            4:       return rd_b[95:64];
            5:       return {31'b0, ready_a};
            6:       return {31'b0, ready_b};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: every expectation due at this cycle is compared against the DUT outputs.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [31:0] got;
                got = pick(sb[i].sel);
                total++;
                if (sb[i].due < cyc || got !== sb[i].val) begin
                    bad++;
                    $display("FAIL chk%0d sel%0d cyc=%0d got=%h want=%h",
                             sb[i].tag, sb[i].sel, cyc, got, sb[i].val);
                end else begin
                    $display("ok   chk%0d sel%0d cyc=%0d val=%h",
                             sb[i].tag, sb[i].sel, cyc, got);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(int sel, logic [31:0] v, int tag);
        exp_t e;
        e.due = cyc + 1;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_a(logic rst, logic we, logic [4:0] a, logic [31:0] d,
                           logic [4:0] r0, logic [4:0] r1);
        rst_a = rst; we_a = we; a3_a = a; wd_a = d; ra_a = {r1, r0};
    endtask

    task automatic exp_a(logic [31:0] v0, logic [31:0] v1, logic rdy, int tag);
        push(0, v0, tag);
        push(1, v1, tag);
        push(5, {31'b0, rdy}, tag);
    endtask

    task automatic drive_b(logic rst, logic we, logic [4:0] a, logic [31:0] d,
                           logic [4:0] r0, logic [4:0] r1, logic [4:0] r2);
        rst_b = rst; we_b = we; a3_b = a; wd_b = d; ra_b = {r2, r1, r0};
    endtask

    task automatic exp_b(logic [31:0] v0, logic [31:0] v1, logic [31:0] v2,
                         logic rdy, int tag);
        push(2, v0, tag);
        push(3, v1, tag);
        push(4, v2, tag);
        push(6, {31'b0, rdy}, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_mem [24];

    initial begin
        drive_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        drive_b(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();

        // Reset held for two edges on bank A; bank B stays in reset meanwhile.
        push(6, 32'h0, 1);
        for (int k = 0; k < 2; k++) begin
            drive_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
            exp_a(32'h0, 32'h0, 1'b0, 1);
            tick();
        end

        // Sweep: ready only after the 32nd edge; a write pulse during INIT is ignored.
        for (int k = 1; k <= 32; k++) begin
            drive_a(1'b1, (k == 20), 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5);
            exp_a(32'h0, 32'h0, (k == 32), 2);
            tick();
        end

        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
        exp_a(32'h0, 32'h0, 1'b1, 3);
        tick();

        drive_a(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        exp_a(BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b1, 4);
        tick();
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        exp_a(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 5);
        tick();

        drive_a(1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd7);
        exp_a(32'h0, 32'hDEAD_BEEF, 1'b1, 6);
        tick();
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        exp_a(32'h0, 32'h0, 1'b1, 7);
        tick();

        // Same-edge read/write hazard on x3.
        drive_a(1'b1, 1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
        exp_a(BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 1'b1, 8);
        tick();
        drive_a(1'b1, 1'b1, 5'd3, 32'h2, 5'd3, 5'd7);
        exp_a(BYP ? 32'h2 : 32'h1, 32'hDEAD_BEEF, 1'b1, 9);
        tick();
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        exp_a(32'h2, 32'h2, 1'b1, 10);
        tick();

        drive_a(1'b1, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd31);
        exp_a(BYP ? 32'hAA : 32'h0, 32'h0, 1'b1, 11);
        tick();
        drive_a(1'b1, 1'b1, 5'd31, 32'h31, 5'd9, 5'd31);
        exp_a(32'hAA, BYP ? 32'h31 : 32'h0, 1'b1, 12);
        tick();
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
        exp_a(32'h31, 32'hAA, 1'b1, 13);
        tick();

        // Reset in RUN, then again at sweep count 10.
        drive_a(1'b0, 1'b1, 5'd9, 32'h55, 5'd9, 5'd31);
        exp_a(32'h0, 32'h0, 1'b0, 14);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
            exp_a(32'h0, 32'h0, 1'b0, 15);
            tick();
        end
        drive_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        exp_a(32'h0, 32'h0, 1'b0, 16);
        tick();
        for (int k = 1; k <= 32; k++) begin
            drive_a(1'b1, (k % 4 == 0), 5'd9, 32'h55, 5'd9, 5'd31);
            exp_a(32'h0, 32'h0, (k == 32), 17);
            tick();
        end
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        exp_a(32'h0, 32'h0, 1'b1, 18);
        tick();
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
        exp_a(32'h0, 32'h0, 1'b1, 19);
        tick();
        drive_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Bank B: 24 entries, 3 ports, no zero register.
        for (int k = 1; k <= 24; k++) begin
            drive_b(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd23);
            exp_b(32'h0, 32'h0, 32'h0, (k == 24), 20);
            tick();
        end

        for (int k = 0; k < 24; k++) exp_mem[k] = 32'h0;
        exp_mem[0]  = 32'h1234_5678;
        exp_mem[1]  = 32'h1111_1111;
        exp_mem[2]  = 32'h2222_2222;
        exp_mem[23] = 32'h2323_2323;

        drive_b(1'b1, 1'b1, 5'd1, 32'h1111_1111, 5'd30, 5'd27, 5'd24);
        exp_b(32'h0, 32'h0, 32'h0, 1'b1, 21);
        tick();
        drive_b(1'b1, 1'b1, 5'd2, 32'h2222_2222, 5'd30, 5'd27, 5'd24);
        exp_b(32'h0, 32'h0, 32'h0, 1'b1, 21);
        tick();
        drive_b(1'b1, 1'b1, 5'd23, 32'h2323_2323, 5'd30, 5'd27, 5'd24);
        exp_b(32'h0, 32'h0, 32'h0, 1'b1, 21);
        tick();
        drive_b(1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd30, 5'd27, 5'd24);
        exp_b(32'h0, 32'h0, 32'h0, 1'b1, 21);
        tick();
        drive_b(1'b1, 1'b1, 5'd27, 32'hBADB_AD00, 5'd30, 5'd27, 5'd24);
        exp_b(32'h0, 32'h0, 32'h0, 1'b1, 22);
        tick();
        drive_b(1'b1, 1'b1, 5'd24, 32'hB0B0_B0B0, 5'd30, 5'd27, 5'd24);
        exp_b(32'h0, 32'h0, 32'h0, 1'b1, 22);
        tick();

        drive_b(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd23);
        exp_b(32'h1111_1111, 32'h2222_2222, 32'h2323_2323, 1'b1, 23);
        tick();
        drive_b(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd30, 5'd27);
        exp_b(32'h1234_5678, 32'h0, 32'h0, 1'b1, 24);
        tick();

        // Full readback: the dropped writes must not have touched any entry.
        for (int g = 0; g < 8; g++) begin
            drive_b(1'b1, 1'b0, 5'd0, 32'h0, 5'(3*g), 5'(3*g+1), 5'(3*g+2));
            exp_b(exp_mem[3*g], exp_mem[3*g+1], exp_mem[3*g+2], 1'b1, 25);
            tick();
        end

        drive_b(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
            total += sb.size();
            bad   += sb.size();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
